packet_rr_arbiter: RTL and testbench

PACKET_RR_ARBITER -- requirements
Module: packet_rr_arbiter

---
 rtl/packet_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_packet_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter: four-input round-robin arbiter for Avalon-ST packet streams.
// It locks onto one input for a whole packet and releases it on the accepted eop.
// Each output beat is held in a single register stage.
module packet_rr_arbiter #(
  parameter int data_width    = 128,
  parameter int empty_width   = $clog2(data_width/8),
  parameter int channel_width = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [4*channel_width-1:0] avsi_channel,
  input  logic [4*data_width-1:0]    avsi_data,
  input  logic [3:0]                 avsi_valid,
  input  logic [3:0]                 avsi_sop,
  input  logic [3:0]                 avsi_eop,
  input  logic [4*empty_width-1:0]   avsi_empty,
  output logic [3:0]                 avsi_ready,
  output logic [channel_width-1:0]   avso_channel,
  output logic [data_width-1:0]      avso_data,
  output logic                       avso_sop,
  output logic                       avso_eop,
  output logic [empty_width-1:0]     avso_empty,
  output logic                       avso_valid,
  input  logic                       avso_ready,
  output logic [1:0]                 grant_id,
  output logic                       busy
);

  // state | meaning
  // IDLE  | no packet owned; pick the next valid input after last_grant
  // LOCK  | input grant_id owns the output until its eop beat is accepted
  typedef enum logic {IDLE, LOCK} state_t;

  state_t                   state;
  logic [1:0]               last_grant;
  logic [1:0]               pick;
  logic [1:0]               idx;
  logic                     out_free;
  logic                     accept;
  logic [channel_width-1:0] lane_channel;
  logic [data_width-1:0]    lane_data;
  logic [empty_width-1:0]   lane_empty;
  logic                     lane_sop;
  logic                     lane_eop;

  // Round-robin pick: scan from the highest offset down so that the nearest input after last_grant wins
  always_comb begin
    pick = 2'd0;
    idx  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (avsi_valid[idx]) pick = idx;
    end
  end

  // The output register can take a beat when it is empty or being drained this cycle.
  // avsi_ready is deliberately independent of avsi_valid.
  always_comb begin
    out_free   = !avso_valid || avso_ready;
    avsi_ready = 4'b0000;
    if (state == LOCK) avsi_ready[grant_id] = out_free;
  end

  // Select the granted lane's fields
  always_comb begin
    lane_channel = avsi_channel[int'(grant_id)*channel_width +: channel_width];
    lane_data    = avsi_data[int'(grant_id)*data_width +: data_width];
    lane_empty   = avsi_empty[int'(grant_id)*empty_width +: empty_width];
    lane_sop     = avsi_sop[grant_id];
    lane_eop     = avsi_eop[grant_id];
    accept       = avsi_valid[grant_id] && avsi_ready[grant_id];
  end

  // Arbitration FSM and the registered output beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant   <= 2'd3;
      grant_id     <= 2'd0;
      busy         <= 1'b0;
      avso_valid   <= 1'b0;
      avso_sop     <= 1'b0;
      avso_eop     <= 1'b0;
      avso_data    <= '0;
      avso_channel <= '0;
      avso_empty   <= '0;
    end else begin
      if (accept) begin
        avso_channel <= lane_channel;
        avso_data    <= lane_data;
        avso_empty   <= lane_empty;
        avso_sop     <= lane_sop;
        avso_eop     <= lane_eop;
        avso_valid   <= 1'b1;
      end else if (avso_valid && avso_ready) begin
        avso_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|avsi_valid) begin
            state    <= LOCK;
            grant_id <= pick;
            busy     <= 1'b1;
          end
        end
        LOCK: begin
          // sop is not checked; only the accepted eop ends the lock
          if (accept && lane_eop) begin
            state      <= IDLE;
            last_grant <= grant_id;
            grant_id   <= 2'd0;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed bench for packet_rr_arbiter. Inputs change 1 ns after each rising edge,
// and outputs are checked at the same point.
module tb_packet_rr_arbiter;
  localparam int DW = 128;
  localparam int EW = 4;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [3:0]      v, s, e;
  logic [DW-1:0]   d  [4];
  logic [CW-1:0]   ch [4];
  logic [EW-1:0]   em [4];

  logic [4*CW-1:0] avsi_channel;
  logic [4*DW-1:0] avsi_data;
  logic [3:0]      avsi_valid, avsi_sop, avsi_eop, avsi_ready;
  logic [4*EW-1:0] avsi_empty;
  logic [CW-1:0]   avso_channel;
  logic [DW-1:0]   avso_data;
  logic            avso_sop, avso_eop, avso_valid, avso_ready;
  logic [EW-1:0]   avso_empty;
  logic [1:0]      grant_id;
  logic            busy;

  int n_pass = 0;
  int n_total = 0;

  packet_rr_arbiter #(.data_width(DW), .empty_width(EW), .channel_width(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .avsi_channel(avsi_channel), .avsi_data(avsi_data), .avsi_valid(avsi_valid),
    .avsi_sop(avsi_sop), .avsi_eop(avsi_eop), .avsi_empty(avsi_empty),
    .avsi_ready(avsi_ready),
    .avso_channel(avso_channel), .avso_data(avso_data), .avso_sop(avso_sop),
    .avso_eop(avso_eop), .avso_empty(avso_empty), .avso_valid(avso_valid),
    .avso_ready(avso_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    avsi_channel = '0;
    avsi_data    = '0;
    avsi_empty   = '0;
    for (int i = 0; i < 4; i++) begin
      avsi_channel[i*CW +: CW] = ch[i];
      avsi_data[i*DW +: DW]    = d[i];
      avsi_empty[i*EW +: EW]   = em[i];
    end
  end

  assign avsi_valid = v;
  assign avsi_sop   = s;
  assign avsi_eop   = e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input logic vv, input logic ss, input logic ee,
                      input logic [DW-1:0] dd);
    v[i] = vv;
    s[i] = ss;
    e[i] = ee;
    d[i] = dd;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    int gg;
    v = '0; s = '0; e = '0;
    for (int i = 0; i < 4; i++) begin
      d[i]  = '0;
      ch[i] = CW'(3*i + 5);
      em[i] = EW'(i + 8);
    end
    avso_ready = 1'b1;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", avso_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_data", avso_data, 0);
    chk("rst_sop", avso_sop, 0);
    chk("rst_eop", avso_eop, 0);
    chk("rst_channel", avso_channel, 0);
    chk("rst_empty", avso_empty, 0);
    chk("rst_ready", avsi_ready, 0);
    tick(); tick();
    reset_n = 1'b1;

    // Single input 2, three beats
    lane(2, 1, 1, 0, 'hA);
    #1;
    chk("idle_ready", avsi_ready, 4'b0000);
    tick();
    chk("s_grant", grant_id, 2);
    chk("s_busy", busy, 1);
    chk("s_valid0", avso_valid, 0);
    chk("s_ready", avsi_ready, 4'b0100);
    tick();
    chk("s_b0_valid", avso_valid, 1);
    chk("s_b0_data", avso_data, 'hA);
    chk("s_b0_sop", avso_sop, 1);
    chk("s_b0_eop", avso_eop, 0);
    chk("s_b0_chan", avso_channel, 11);
    chk("s_b0_empty", avso_empty, 10);
    lane(2, 1, 0, 0, 'hB);
    tick();
    chk("s_b1_data", avso_data, 'hB);
    chk("s_b1_sop", avso_sop, 0);
    lane(2, 1, 0, 1, 'hC);
    tick();
    chk("s_b2_data", avso_data, 'hC);
    chk("s_b2_eop", avso_eop, 1);
    chk("s_done_busy", busy, 0);
    chk("s_done_grant", grant_id, 0);
    lane(2, 0, 0, 0, 0);
    tick();
    chk("s_drain", avso_valid, 0);

    // last_grant is 2: with 0,1,3 valid the next pick is 3; single-beat packet on 3
    lane(0, 1, 1, 1, 'h100);
    lane(1, 1, 1, 1, 'h110);
    lane(3, 1, 1, 1, 'h33);
    tick();
    chk("lg_grant", grant_id, 3);
    chk("lg_busy", busy, 1);
    tick();
    chk("sb_data", avso_data, 'h33);
    chk("sb_sop", avso_sop, 1);
    chk("sb_eop", avso_eop, 1);
    chk("sb_busy", busy, 0);
    lane(0, 0, 0, 0, 0);
    lane(1, 0, 0, 0, 0);
    lane(3, 0, 0, 0, 0);
    tick();
    chk("sb_drain", avso_valid, 0);

    // Fairness: all four inputs continuously valid with 2-beat packets
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) lane(i, 1, 1, 0, DW'(16*i));
    for (int p = 0; p < 5; p++) begin
      gg = p % 4;
      tick();
      chk("f_grant", grant_id, DW'(gg));
      chk("f_busy", busy, 1);
      chk("f_bubble", avso_valid, 0);
      chk("f_ready", avsi_ready, DW'(4'b0001 << gg));
      tick();
      chk("f_b0_data", avso_data, DW'(16*gg));
      chk("f_b0_sop", avso_sop, 1);
      chk("f_b0_chan", avso_channel, DW'(3*gg + 5));
      lane(gg, 1, 0, 1, DW'(16*gg + 1));
      tick();
      chk("f_b1_data", avso_data, DW'(16*gg + 1));
      chk("f_b1_eop", avso_eop, 1);
      chk("f_b1_valid", avso_valid, 1);
      chk("f_b1_busy", busy, 0);
      lane(gg, 1, 1, 0, DW'(16*gg));
    end

    // Lock hold on input 1 plus backpressure
    lane(0, 0, 0, 0, 0);
    lane(2, 0, 0, 0, 0);
    lane(3, 0, 0, 0, 0);
    lane(1, 1, 1, 0, 'h200);
    tick();
    chk("lh_grant", grant_id, 1);
    tick();
    chk("lh_b0_data", avso_data, 'h200);
    lane(0, 1, 1, 0, 'h300);
    lane(1, 0, 0, 0, 'h201);
    #1;
    chk("lh_ready_novalid", avsi_ready, 4'b0010);
    tick();
    chk("lh_gap1_valid", avso_valid, 0);
    chk("lh_gap1_grant", grant_id, 1);
    chk("lh_gap1_busy", busy, 1);
    tick();
    chk("lh_gap2_valid", avso_valid, 0);
    chk("lh_gap2_grant", grant_id, 1);
    lane(1, 1, 0, 0, 'h201);
    tick();
    chk("lh_b1_data", avso_data, 'h201);
    chk("lh_b1_valid", avso_valid, 1);
    avso_ready = 1'b0;
    lane(1, 1, 0, 1, 'h202);
    #1;
    chk("bp_ready", avsi_ready, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", avso_valid, 1);
      chk("bp_data", avso_data, 'h201);
      chk("bp_ready_hold", avsi_ready, 4'b0000);
      chk("bp_grant", grant_id, 1);
    end
    avso_ready = 1'b1;
    #1;
    chk("bp_release_ready", avsi_ready, 4'b0010);
    tick();
    chk("lh_b2_data", avso_data, 'h202);
    chk("lh_b2_eop", avso_eop, 1);
    chk("lh_b2_busy", busy, 0);
    lane(1, 0, 0, 0, 0);
    tick();
    chk("lh_next_grant", grant_id, 0);
    chk("lh_next_bubble", avso_valid, 0);
    tick();
    chk("r_b0_data", avso_data, 'h300);
    chk("r_b0_valid", avso_valid, 1);

    // Reset mid-packet on input 0
    lane(0, 1, 0, 0, 'h301);
    lane(1, 1, 1, 0, 'h400);
    lane(3, 1, 1, 0, 'h430);
    reset_n = 1'b0;
    #1;
    chk("r_valid", avso_valid, 0);
    chk("r_data", avso_data, 0);
    chk("r_sop", avso_sop, 0);
    chk("r_chan", avso_channel, 0);
    chk("r_busy", busy, 0);
    chk("r_grant", grant_id, 0);
    chk("r_ready", avsi_ready, 0);
    tick(); tick();
    lane(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();
    chk("r_next_grant", grant_id, 1);
    chk("r_next_busy", busy, 1);
    tick();
    chk("r_next_data", avso_data, 'h400);
    chk("r_next_chan", avso_channel, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
